alto_disk_word_timer: RTL and testbench



---
 rtl/alto_disk_word_timer_pkg.sv | 15 +
 rtl/alto_disk_interval_counter.sv | 26 ++
 rtl/alto_disk_word_timer.sv | 178 +++++++++++++++++
 tb/tb_alto_disk_word_timer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alto_disk_word_timer_pkg.sv
// Alto disk word timer: shared state and record codes.
// Imported by the word timer top; no ports.
package alto_disk_word_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_WORD = 2'd2
  } wt_state_e;

  localparam logic [1:0] REC_HEADER = 2'd0;
  localparam logic [1:0] REC_LABEL  = 2'd1;
  localparam logic [1:0] REC_DATA   = 2'd2;

endpackage

// File: rtl/alto_disk_interval_counter.sv
// 9-bit loadable down-counter shared by gap and slot timing.
// Ports: clk_i, rst_i, load_i, load_val_i[8:0], en_i -> tc_o (count==0).
module alto_disk_interval_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [8:0] load_val_i,
  input  logic       en_i,
  output logic       tc_o
);

  logic [8:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && count_q != 9'd0) begin
      count_q <= count_q - 9'd1;
    end
  end

  assign tc_o = (count_q == 9'd0);

endmodule

// File: rtl/alto_disk_word_timer.sv
// Disk word-task wakeup timer: header/label/data records, each a gap
// then fixed word slots; raises word_req_o, tracks position, data-late.
// Ports: clk_i, rst_i, sector_start_i, xfer_en_i, rec_en_i[2:0],
//   word_ack_i, clr_late_i -> word_req_o, wdinit_o, data_late_o,
//   record_o[1:0], word_index_o[8:0], busy_o, done_o.
// Option: ALTO_DISK_WORD_TIMER_CHECKSUM_EN adds a trailing checksum slot.
module alto_disk_word_timer
  import alto_disk_word_timer_pkg::*;
#(
  parameter int WORD_CYCLES = 64,
  parameter int GAP_CYCLES  = 320,
  parameter int HDR_WORDS   = 2,
  parameter int LBL_WORDS   = 8,
  parameter int DATA_WORDS  = 256
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sector_start_i,
  input  logic       xfer_en_i,
  input  logic [2:0] rec_en_i,
  input  logic       word_ack_i,
  input  logic       clr_late_i,
  output logic       word_req_o,
  output logic       wdinit_o,
  output logic       data_late_o,
  output logic [1:0] record_o,
  output logic [8:0] word_index_o,
  output logic       busy_o,
  output logic       done_o
);

`ifdef ALTO_DISK_WORD_TIMER_CHECKSUM_EN
  localparam int XTRA = 1;
`else
  localparam int XTRA = 0;
`endif

  localparam logic [8:0] GAP_LD    = 9'(GAP_CYCLES - 1);
  localparam logic [8:0] WORD_LD   = 9'(WORD_CYCLES - 1);
  localparam logic [8:0] HDR_LAST  = 9'(HDR_WORDS - 1 + XTRA);
  localparam logic [8:0] LBL_LAST  = 9'(LBL_WORDS - 1 + XTRA);
  localparam logic [8:0] DATA_LAST = 9'(DATA_WORDS - 1 + XTRA);

  wt_state_e  state_q, state_d;
  logic [1:0] rec_q, rec_d;
  logic [8:0] idx_q, idx_d;
  logic       on_q, on_d;
  logic       req_q, req_d;
  logic       late_q, late_d;

  logic       ld, cnt_en, tc;
  logic [8:0] ld_val, last_idx;
  logic       wdinit, done, slot_new, on_new;

  alto_disk_interval_counter u_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (ld),
    .load_val_i (ld_val),
    .en_i       (cnt_en),
    .tc_o       (tc)
  );

  always_comb begin
    unique case (rec_q)
      REC_HEADER: last_idx = HDR_LAST;
      REC_LABEL:  last_idx = LBL_LAST;
      default:    last_idx = DATA_LAST;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rec_q   <= REC_HEADER;
      idx_q   <= '0;
      on_q    <= 1'b0;
      req_q   <= 1'b0;
      late_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
      idx_q   <= idx_d;
      on_q    <= on_d;
      req_q   <= req_d;
      late_q  <= late_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rec_d    = rec_q;
    idx_d    = idx_q;
    on_d     = on_q;
    req_d    = req_q;
    late_d   = late_q;
    ld       = 1'b0;
    ld_val   = GAP_LD;
    cnt_en   = 1'b0;
    wdinit   = 1'b0;
    done     = 1'b0;
    slot_new = 1'b0;
    on_new   = on_q;

    if (clr_late_i) late_d = 1'b0;
    if (word_ack_i) req_d = 1'b0;

    unique case (1'b1)
      sector_start_i && xfer_en_i: begin
        state_d = ST_GAP;
        rec_d   = REC_HEADER;
        idx_d   = '0;
        on_d    = 1'b0;
        req_d   = 1'b0;
        ld      = 1'b1;
        ld_val  = GAP_LD;
      end
      !xfer_en_i: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
      default: begin
        unique case (state_q)
          ST_GAP: begin
            if (tc) begin
              state_d  = ST_WORD;
              idx_d    = '0;
              on_new   = rec_en_i[rec_q];
              on_d     = on_new;
              wdinit   = on_new;
              slot_new = 1'b1;
              ld       = 1'b1;
              ld_val   = WORD_LD;
            end else begin
              cnt_en = 1'b1;
            end
          end
          ST_WORD: begin
            if (!tc) begin
              cnt_en = 1'b1;
            end else if (idx_q < last_idx) begin
              idx_d    = idx_q + 9'd1;
              slot_new = 1'b1;
              ld       = 1'b1;
              ld_val   = WORD_LD;
            end else if (rec_q != REC_DATA) begin
              rec_d   = rec_q + 2'd1;
              state_d = ST_GAP;
              ld      = 1'b1;
              ld_val  = GAP_LD;
            end else begin
              state_d = ST_IDLE;
              done    = 1'b1;
              req_d   = 1'b0;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    endcase

    // A pending, unacked request at a slot boundary is late and stays
    // raised; otherwise the new slot's request overrides any ack.
    if (slot_new) begin
      if (req_q && !word_ack_i) late_d = 1'b1;
      else req_d = on_new;
    end
  end

  assign word_req_o   = req_q;
  assign data_late_o  = late_q;
  assign record_o     = rec_q;
  assign word_index_o = idx_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign wdinit_o     = wdinit & ~rst_i;
  assign done_o       = done & ~rst_i;

endmodule

// File: tb/tb_alto_disk_word_timer.sv
// Self-checking bench for alto_disk_word_timer (small timing params).
// Table-driven sector runs plus directed drop/late/reset sequences.
module tb_alto_disk_word_timer;

`ifdef ALTO_DISK_WORD_TIMER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, sector_start, xfer_en, ack, clr_late;
  logic [2:0] rec_en;
  logic       req, wdinit, late, busy, done;
  logic [1:0] record;
  logic [8:0] word_index;

  always #5 clk = ~clk;

  alto_disk_word_timer #(
    .WORD_CYCLES(4), .GAP_CYCLES(8),
    .HDR_WORDS(2), .LBL_WORDS(3), .DATA_WORDS(4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .sector_start_i (sector_start),
    .xfer_en_i      (xfer_en),
    .rec_en_i       (rec_en),
    .word_ack_i     (ack),
    .clr_late_i     (clr_late),
    .word_req_o     (req),
    .wdinit_o       (wdinit),
    .data_late_o    (late),
    .record_o       (record),
    .word_index_o   (word_index),
    .busy_o         (busy),
    .done_o         (done)
  );

  typedef struct {
    logic [2:0] en;
    bit         ack;
    int wd_n, wd_first, rises, rise_first, done_c, late_c, max_idx;
  } vec_t;

  typedef struct {
    int wd_n, wd_first, rises, rise_first, done_c, late_c, max_idx;
    int req_after, busy_after;
  } res_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; sector_start = 1'b0; ack = 1'b0;
    clr_late = 1'b0; xfer_en = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start(input logic [2:0] en);
    rec_en = en;
    sector_start = 1'b1;
    cyc = 0;
    tick();
    sector_start = 1'b0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic run_vec(input vec_t v, output res_t r);
    logic prev;
    r = '{default: 0};
    prev = 1'b0;
    pulse_start(v.en);
    for (int c = 0; c < 400; c++) begin
      if (wdinit) begin
        r.wd_n++;
        if (r.wd_first == 0) r.wd_first = cyc;
      end
      if (req && !prev) begin
        r.rises++;
        if (r.rise_first == 0) r.rise_first = cyc;
      end
      prev = req;
      if (late && r.late_c == 0) r.late_c = cyc;
      if (record == 2'd2 && int'(word_index) > r.max_idx)
        r.max_idx = int'(word_index);
      if (done) r.done_c = cyc;
      ack = v.ack && req;
      tick();
      if (r.done_c != 0 && cyc == r.done_c + 1) begin
        r.req_after = int'(req);
        r.busy_after = int'(busy);
        break;
      end
    end
    ack = 1'b0;
  endtask

  vec_t vecs[5];
  res_t r;
  int   dn;

  initial begin
    rec_en = 3'b111;
    vecs[0] = '{3'b111, 1'b1, 3, 8, 9 + 3*CK, 9, 60 + 12*CK, 0, 3 + CK};
    vecs[1] = '{3'b111, 1'b0, 3, 8, 1, 9, 60 + 12*CK, 13, 3 + CK};
    vecs[2] = '{3'b100, 1'b1, 1, 44 + 8*CK, 4 + CK, 45 + 8*CK,
                60 + 12*CK, 0, 3 + CK};
    vecs[3] = '{3'b011, 1'b1, 2, 8, 5 + 2*CK, 9, 60 + 12*CK, 0, 3 + CK};
    vecs[4] = '{3'b000, 1'b0, 0, 0, 0, 0, 60 + 12*CK, 0, 3 + CK};

    do_reset();
    check("rst_req", int'(req), 0);
    check("rst_late", int'(late), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_record", int'(record), 0);
    check("rst_index", int'(word_index), 0);
    check("rst_wdinit", int'(wdinit), 0);
    check("rst_done", int'(done), 0);

    xfer_en = 1'b0;
    sector_start = 1'b1;
    tick();
    sector_start = 1'b0;
    tick();
    check("start_xfer_off_ignored", int'(busy), 0);
    xfer_en = 1'b1;

    for (int i = 0; i < 5; i++) begin
      do_reset();
      run_vec(vecs[i], r);
      check($sformatf("v%0d_wdinit_n", i), r.wd_n, vecs[i].wd_n);
      check($sformatf("v%0d_wdinit_first", i), r.wd_first, vecs[i].wd_first);
      check($sformatf("v%0d_req_rises", i), r.rises, vecs[i].rises);
      check($sformatf("v%0d_req_first", i), r.rise_first, vecs[i].rise_first);
      check($sformatf("v%0d_done_cycle", i), r.done_c, vecs[i].done_c);
      check($sformatf("v%0d_late_cycle", i), r.late_c, vecs[i].late_c);
      check($sformatf("v%0d_data_max_idx", i), r.max_idx, vecs[i].max_idx);
      check($sformatf("v%0d_req_after_done", i), r.req_after, 0);
      check($sformatf("v%0d_busy_after_done", i), r.busy_after, 0);
    end

    do_reset();
    pulse_start(3'b111);
    run_to(20);
    check("midrst_late_before", int'(late), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_req", int'(req), 0);
    check("midrst_late", int'(late), 0);
    check("midrst_index", int'(word_index), 0);

    do_reset();
    pulse_start(3'b111);
    run_to(30 + 4*CK);
    check("drop_pre_record", int'(record), 1);
    check("drop_pre_index", int'(word_index), 1);
    xfer_en = 1'b0;
    tick();
    check("drop_busy", int'(busy), 0);
    check("drop_req", int'(req), 0);
    check("drop_late_kept", int'(late), 1);
    dn = 0;
    for (int c = 0; c < 80; c++) begin
      if (done) dn++;
      tick();
    end
    check("drop_no_done", dn, 0);
    xfer_en = 1'b1;
    pulse_start(3'b111);
    check("restart_busy", int'(busy), 1);
    check("restart_record", int'(record), 0);
    check("restart_index", int'(word_index), 0);

    do_reset();
    pulse_start(3'b111);
    run_to(24 + 4*CK);
    check("clr_pre_late", int'(late), 1);
    clr_late = 1'b1;
    tick();
    clr_late = 1'b0;
    check("clr_vs_late_set_wins", int'(late), 1);
    check("clr_vs_late_req", int'(req), 1);
    clr_late = 1'b1;
    tick();
    clr_late = 1'b0;
    tick();
    check("lone_clr", int'(late), 0);
    check("busy_restart_pre_req", int'(req), 1);
    pulse_start(3'b111);
    check("busy_restart_req", int'(req), 0);
    check("busy_restart_record", int'(record), 0);
    check("busy_restart_index", int'(word_index), 0);
    check("busy_restart_busy", int'(busy), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
